// File: rtl/qpsk_pkg.sv
// qpsk_pkg: shared QPSK constants and desynchronizer state type.
package qpsk_pkg;
    localparam int SYMBOL_CYCLES_DEF = 52;
    localparam int NIBBLE_W_DEF = 4;
    typedef enum logic [1:0] {IDLE, HUNT, RUN} desync_state_t;
endpackage

// File: rtl/qpsk_bit_sampler.sv
// qpsk_bit_sampler: mid-symbol bit decision for one stream.
// QPSK_DESYNC_MAJORITY_EN selects a 2-of-3 vote around SAMPLE_POINT, strobing one clk later.
module qpsk_bit_sampler #(
    parameter int CW = 6,
    parameter int SAMPLE_POINT = 26
) (
`ifdef QPSK_DESYNC_MAJORITY_EN
    input  logic          clk,
    input  logic          reset,
`endif
    input  logic [CW-1:0] cnt,
    input  logic          bit_in,
    output logic          bit_out,
    output logic          strobe
);
`ifdef QPSK_DESYNC_MAJORITY_EN
    logic [1:0] hist;
    always_ff @(posedge clk or negedge reset)
        if (!reset) hist <= '0;
        else hist <= {hist[0], bit_in};
    // hist holds the samples from SAMPLE_POINT-1 and SAMPLE_POINT when cnt reaches SAMPLE_POINT+1
    assign bit_out = (hist[1] & hist[0]) | (hist[1] & bit_in) | (hist[0] & bit_in);
    assign strobe = cnt == CW'(SAMPLE_POINT + 1);
`else
    assign bit_out = bit_in;
    assign strobe = cnt == CW'(SAMPLE_POINT);
`endif
endmodule

// File: rtl/qpsk_desynchronizer.sv
// qpsk_desynchronizer: reassembles even/odd bit streams into nibble pairs on a valid/ready port.
// QPSK_DESYNC_MAJORITY_EN enables majority-vote sampling (one extra clk of latency).
module qpsk_desynchronizer
    import qpsk_pkg::*;
#(
    parameter int SYMBOL_CYCLES = SYMBOL_CYCLES_DEF,
    parameter int SAMPLE_POINT = 26,
    parameter int NIBBLE_W = NIBBLE_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                sym_start,
    input  logic                even_in,
    input  logic                odd_in,
    output logic [NIBBLE_W-1:0] dataeve,
    output logic [NIBBLE_W-1:0] dataodd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun,
    output logic                locked
);
    localparam int CW = SYMBOL_CYCLES > 1 ? $clog2(SYMBOL_CYCLES) : 1;
    localparam int IW = NIBBLE_W > 1 ? $clog2(NIBBLE_W) : 1;

    desync_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_eff;
    logic [IW-1:0] idx, idx_eff;
    logic start, active, samp, done, last_cnt, last_idx;
    logic even_bit, odd_bit, even_stb, odd_stb;
    logic [NIBBLE_W-1:0] even_sr, odd_sr, even_nib, odd_nib;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= HUNT;
        else state <= state_nx;

    always_comb
        state_nx = !en ? IDLE :
                   state == IDLE ? HUNT :
                   (state == HUNT && sym_start) ? RUN : state;

    always_comb locked = state == RUN;

    // a sym_start pulse makes its own clock count as cnt=0, idx=0
    assign start = en && sym_start && state != IDLE;
    assign active = en && (state == RUN || start);
    assign cnt_eff = start ? '0 : cnt;
    assign idx_eff = start ? '0 : idx;
    assign last_cnt = cnt_eff == CW'(SYMBOL_CYCLES - 1);
    assign last_idx = idx_eff == IW'(NIBBLE_W - 1);
    assign samp = active && even_stb && odd_stb;
    assign done = samp && last_idx;

    qpsk_bit_sampler #(.CW(CW), .SAMPLE_POINT(SAMPLE_POINT)) u_even (
`ifdef QPSK_DESYNC_MAJORITY_EN
        .clk(clk), .reset(reset),
`endif
        .cnt(cnt_eff), .bit_in(even_in), .bit_out(even_bit), .strobe(even_stb)
    );

    qpsk_bit_sampler #(.CW(CW), .SAMPLE_POINT(SAMPLE_POINT)) u_odd (
`ifdef QPSK_DESYNC_MAJORITY_EN
        .clk(clk), .reset(reset),
`endif
        .cnt(cnt_eff), .bit_in(odd_in), .bit_out(odd_bit), .strobe(odd_stb)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (!active) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= last_cnt ? '0 : cnt_eff + 1'b1;
            idx <= !last_cnt ? idx_eff : last_idx ? '0 : idx_eff + 1'b1;
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            even_sr <= '0;
            odd_sr <= '0;
        end else if (samp) begin
            even_sr[idx_eff] <= even_bit;
            odd_sr[idx_eff] <= odd_bit;
        end

    // completed nibble includes the bit being sampled this clock
    always_comb begin
        even_nib = even_sr;
        odd_nib = odd_sr;
        even_nib[NIBBLE_W-1] = even_bit;
        odd_nib[NIBBLE_W-1] = odd_bit;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            dataeve <= '0;
            dataodd <= '0;
            out_valid <= 1'b0;
            overrun <= 1'b0;
        end else if (done && out_valid && !out_ready) begin
            overrun <= 1'b1;
        end else if (done) begin
            dataeve <= even_nib;
            dataodd <= odd_nib;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
endmodule
